// File: rtl/sync_memory_ctrl.sv
// Single-port synchronous memory with masked writes,
// registered reads and a built-in array fill engine.
module sync_memory_ctrl #(
  parameter int ADDR_SIZE   = 10,
  parameter int WORD_SIZE   = 8,
  parameter int MEMORY_SIZE = 1024,
  parameter int FILL_MODE   = 1,
  parameter int FILL_VALUE  = 0,
  parameter int AUTO_INIT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 wr,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [WORD_SIZE-1:0] wmask,
  input  logic                 init_req,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic {IDLE, FILL} state_e;

  localparam state_e RST_STATE =
    (AUTO_INIT != 0) ? FILL : IDLE;
  localparam logic [ADDR_SIZE:0] MEM_SZ =
    (ADDR_SIZE+1)'(MEMORY_SIZE);
  localparam logic [ADDR_SIZE-1:0] LAST =
    ADDR_SIZE'(MEMORY_SIZE - 1);

  logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] ptr_q, ptr_d;
  logic [WORD_SIZE-1:0] dout_q, dout_d;
  logic                 rv_q, rv_d;
  logic                 err_q, err_d;

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_wa;
  logic [WORD_SIZE-1:0] mem_wd;
  logic [WORD_SIZE-1:0] fill_word;
  logic                 in_range;

  assign fill_word = (FILL_MODE != 0)
    ? WORD_SIZE'({ptr_q, 1'b0})
    : WORD_SIZE'(FILL_VALUE);

  assign in_range = {1'b0, addr} < MEM_SZ;

  // Next-state, access decode and array write request
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = ptr_q;
    mem_wd  = fill_word;
    case (state_q)
      FILL: begin
        mem_we = 1'b1;
        if (cs) err_d = 1'b1;
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_SIZE'(1);
        end
      end
      IDLE: begin
        if (cs) begin
          if (!in_range) begin
            err_d = 1'b1;
            if (!wr) begin
              dout_d = '0;
              rv_d   = 1'b1;
            end
          end else if (wr) begin
            mem_we = 1'b1;
            mem_wa = addr;
            mem_wd = (mem[addr] & ~wmask)
                   | (data_in & wmask);
          end else begin
            dout_d = mem[addr];
            rv_d   = 1'b1;
          end
        end
        if (init_req) begin
          state_d = FILL;
          ptr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and read-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
      dout_q  <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign data_out = dout_q;
  assign rd_valid = rv_q;
  assign busy     = (state_q == FILL);
  assign err      = err_q;

endmodule

// File: tb/tb_sync_memory_ctrl.sv
// Directed bench for sync_memory_ctrl across three
// parameter sets: defaults, 1000 words, constant fill.
module tb_sync_memory_ctrl;

  logic       clk;
  logic       rst      [3];
  logic       cs       [3];
  logic       wr       [3];
  logic [9:0] addr     [3];
  logic [7:0] din      [3];
  logic [7:0] wmask    [3];
  logic       init_req [3];
  logic [7:0] dout     [3];
  logic       rv       [3];
  logic       busy     [3];
  logic       err      [3];

  int errors = 0;
  int checks = 0;

  sync_memory_ctrl u0 (
    .clk(clk), .rst(rst[0]), .cs(cs[0]), .wr(wr[0]),
    .addr(addr[0]), .data_in(din[0]), .wmask(wmask[0]),
    .init_req(init_req[0]), .data_out(dout[0]),
    .rd_valid(rv[0]), .busy(busy[0]), .err(err[0])
  );

  sync_memory_ctrl #(.MEMORY_SIZE(1000)) u1 (
    .clk(clk), .rst(rst[1]), .cs(cs[1]), .wr(wr[1]),
    .addr(addr[1]), .data_in(din[1]), .wmask(wmask[1]),
    .init_req(init_req[1]), .data_out(dout[1]),
    .rd_valid(rv[1]), .busy(busy[1]), .err(err[1])
  );

  sync_memory_ctrl #(
    .FILL_MODE(0), .FILL_VALUE(8'h5A), .AUTO_INIT(0)
  ) u2 (
    .clk(clk), .rst(rst[2]), .cs(cs[2]), .wr(wr[2]),
    .addr(addr[2]), .data_in(din[2]), .wmask(wmask[2]),
    .init_req(init_req[2]), .data_out(dout[2]),
    .rd_valid(rv[2]), .busy(busy[2]), .err(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input int d, input logic w,
                     input logic [9:0] a,
                     input logic [7:0] di,
                     input logic [7:0] m);
    cs[d] = 1'b1; wr[d] = w; addr[d] = a;
    din[d] = di; wmask[d] = m;
    step();
    cs[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, output int n);
    n = 0;
    while (busy[d] && n < 3000) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dout[d] !== 8'h00 || rv[d] !== 1'b0
          || err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outs dut%0d: dout=%h rv=%b err=%b want 00/0/0",
                 d, dout[d], rv[d], err[d]);
      end
    end
    checks++;
    if (busy[0] !== 1'b1 || busy[1] !== 1'b1
        || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b%b%b want 110",
               busy[0], busy[1], busy[2]);
    end
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
  endtask

  task automatic test_auto_fill();
    int n0 = 0, n1 = 0;
    while (busy[0] && n0 < 3000) begin
      n0++;
      if (busy[1]) n1++;
      step();
    end
    checks++;
    if (n0 !== 1024) begin
      errors++;
      $display("FAIL fill_len0: got %0d want 1024", n0);
    end
    checks++;
    if (n1 !== 1000) begin
      errors++;
      $display("FAIL fill_len1: got %0d want 1000", n1);
    end
  endtask

  task automatic test_read_pattern();
    logic [9:0] a [4] = '{10'd0, 10'd5, 10'd200, 10'd1023};
    logic [7:0] e [4] = '{8'd0, 8'd10, 8'd144, 8'd254};
    for (int i = 0; i < 4; i++) begin
      acc(0, 1'b0, a[i], 8'h00, 8'h00);
      checks++;
      if (dout[0] !== e[i] || rv[0] !== 1'b1
          || err[0] !== 1'b0) begin
        errors++;
        $display("FAIL read_%0d: dout=%h rv=%b err=%b want %h/1/0",
                 a[i], dout[0], rv[0], err[0], e[i]);
      end
    end
    step();
    checks++;
    if (rv[0] !== 1'b0 || dout[0] !== 8'd254) begin
      errors++;
      $display("FAIL read_idle: rv=%b dout=%h want 0/fe",
               rv[0], dout[0]);
    end
  endtask

  task automatic test_masked_write();
    acc(0, 1'b1, 10'd17, 8'hA5, 8'hFF);
    checks++;
    if (rv[0] !== 1'b0 || dout[0] !== 8'd254
        || err[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_resp: rv=%b dout=%h err=%b want 0/fe/0",
               rv[0], dout[0], err[0]);
    end
    acc(0, 1'b1, 10'd17, 8'h3C, 8'h0F);
    acc(0, 1'b0, 10'd17, 8'h00, 8'h00);
    checks++;
    if (dout[0] !== 8'hAC || rv[0] !== 1'b1) begin
      errors++;
      $display("FAIL mask_rd: dout=%h rv=%b want ac/1",
               dout[0], rv[0]);
    end
    step();
    checks++;
    if (rv[0] !== 1'b0 || dout[0] !== 8'hAC) begin
      errors++;
      $display("FAIL mask_hold: rv=%b dout=%h want 0/ac",
               rv[0], dout[0]);
    end
  endtask

  task automatic test_busy_access();
    int n = 0;
    init_req[0] = 1'b1;
    step();
    init_req[0] = 1'b0;
    while (busy[0] && n < 3000) begin
      n++;
      if (n == 5) begin
        cs[0] = 1'b1; wr[0] = 1'b0; addr[0] = 10'd3;
      end
      if (n == 6) begin
        cs[0] = 1'b0;
        checks++;
        if (err[0] !== 1'b1 || rv[0] !== 1'b0
            || dout[0] !== 8'hAC) begin
          errors++;
          $display("FAIL busy_rd: err=%b rv=%b dout=%h want 1/0/ac",
                   err[0], rv[0], dout[0]);
        end
      end
      if (n == 7) begin
        checks++;
        if (err[0] !== 1'b0) begin
          errors++;
          $display("FAIL err_pulse: err=%b want 0", err[0]);
        end
      end
      init_req[0] = (n == 100);
      step();
    end
    init_req[0] = 1'b0;
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL refill_len: got %0d want 1024", n);
    end
    acc(0, 1'b0, 10'd17, 8'h00, 8'h00);
    checks++;
    if (dout[0] !== 8'd34 || rv[0] !== 1'b1) begin
      errors++;
      $display("FAIL refill_17: dout=%h rv=%b want 22/1",
               dout[0], rv[0]);
    end
  endtask

  task automatic test_reset_mid_fill();
    int n = 0;
    acc(0, 1'b0, 10'd5, 8'h00, 8'h00);
    cs[0] = 1'b1; wr[0] = 1'b1; addr[0] = 10'd40;
    din[0] = 8'hFF; wmask[0] = 8'hFF; init_req[0] = 1'b1;
    step();
    cs[0] = 1'b0; wr[0] = 1'b0; init_req[0] = 1'b0;
    repeat (300) step();
    rst[0] = 1'b1;
    #1;
    checks++;
    if (busy[0] !== 1'b1 || dout[0] !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: busy=%b dout=%h want 1/00",
               busy[0], dout[0]);
    end
    step();
    rst[0] = 1'b0;
    wait_idle(0, n);
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL rst_refill_len: got %0d want 1024", n);
    end
    acc(0, 1'b0, 10'd600, 8'h00, 8'h00);
    acc(0, 1'b0, 10'd40, 8'h00, 8'h00);
    checks++;
    if (dout[0] !== 8'd80) begin
      errors++;
      $display("FAIL init_wr_40: dout=%h want 50", dout[0]);
    end
  endtask

  task automatic test_read_600();
    acc(0, 1'b0, 10'd600, 8'h00, 8'h00);
    checks++;
    if (dout[0] !== 8'd176 || rv[0] !== 1'b1) begin
      errors++;
      $display("FAIL read_600: dout=%h rv=%b want b0/1",
               dout[0], rv[0]);
    end
  endtask

  task automatic test_out_of_range();
    acc(1, 1'b0, 10'd5, 8'h00, 8'h00);
    acc(1, 1'b1, 10'd1010, 8'hFF, 8'hFF);
    checks++;
    if (err[1] !== 1'b1 || rv[1] !== 1'b0
        || dout[1] !== 8'd10) begin
      errors++;
      $display("FAIL oor_wr: err=%b rv=%b dout=%h want 1/0/0a",
               err[1], rv[1], dout[1]);
    end
    acc(1, 1'b0, 10'd1010, 8'h00, 8'h00);
    checks++;
    if (err[1] !== 1'b1 || rv[1] !== 1'b1
        || dout[1] !== 8'h00) begin
      errors++;
      $display("FAIL oor_rd: err=%b rv=%b dout=%h want 1/1/00",
               err[1], rv[1], dout[1]);
    end
    step();
    checks++;
    if (err[1] !== 1'b0 || rv[1] !== 1'b0) begin
      errors++;
      $display("FAIL oor_pulse: err=%b rv=%b want 0/0",
               err[1], rv[1]);
    end
    acc(1, 1'b0, 10'd0, 8'h00, 8'h00);
    acc(1, 1'b0, 10'd999, 8'h00, 8'h00);
    checks++;
    if (dout[1] !== 8'd206 || err[1] !== 1'b0) begin
      errors++;
      $display("FAIL oor_keep999: dout=%h err=%b want ce/0",
               dout[1], err[1]);
    end
  endtask

  task automatic test_const_fill();
    int n = 0;
    acc(2, 1'b1, 10'd9, 8'h11, 8'hFF);
    acc(2, 1'b0, 10'd9, 8'h00, 8'h00);
    checks++;
    if (dout[2] !== 8'h11 || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL const_pre: dout=%h busy=%b want 11/0",
               dout[2], busy[2]);
    end
    init_req[2] = 1'b1;
    step();
    init_req[2] = 1'b0;
    wait_idle(2, n);
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL const_len: got %0d want 1024", n);
    end
    acc(2, 1'b0, 10'd9, 8'h00, 8'h00);
    checks++;
    if (dout[2] !== 8'h5A || rv[2] !== 1'b1) begin
      errors++;
      $display("FAIL const_rd: dout=%h rv=%b want 5a/1",
               dout[2], rv[2]);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; cs[d] = 1'b0; wr[d] = 1'b0;
      addr[d] = '0; din[d] = '0; wmask[d] = '0;
      init_req[d] = 1'b0;
    end
    test_reset();
    test_auto_fill();
    test_read_pattern();
    test_masked_write();
    test_busy_access();
    test_reset_mid_fill();
    test_read_600();
    test_out_of_range();
    test_const_fill();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
